// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: bus widths, response codes and a byte-strobe merge helper.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Replace only the bytes of cur whose strobe bit is set.
    function automatic logic [AXI_DATA_W-1:0] strb_merge(
        input logic [AXI_DATA_W-1:0] cur,
        input logic [AXI_DATA_W-1:0] wdata,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_wr_regs_if.sv
// AXI-Lite write channels (AW, W, B) bundled with master and slave views.
interface axil_slave_wr_regs_if;
    import axi_lite_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/axil_regfile_bytewr.sv
// NUM_REGS x 32-bit register array with indexed byte-strobed writes and a flat read-out.
module axil_regfile_bytewr
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                           i_clk,
    input  logic                           i_resetn,
    input  logic                           we_i,
    input  logic [$clog2(NUM_REGS)-1:0]    idx_i,
    input  logic [AXI_DATA_W-1:0]          data_i,
    input  logic [AXI_STRB_W-1:0]          strb_i,
    output logic [NUM_REGS*AXI_DATA_W-1:0] regs_o
);

    logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we_i) begin
            regs_q[idx_i] <= strb_merge(regs_q[idx_i], data_i, strb_i);
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*AXI_DATA_W +: AXI_DATA_W] = regs_q[k];
    end

endmodule

// File: rtl/axil_slave_wr_regs.sv
// AXI-Lite write responder: independent AW/W holding slots, address decode, B response
// and commit into a byte-strobed register file exported flat.
module axil_slave_wr_regs
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                           i_clk,
    input  logic                           i_resetn,
    axil_slave_wr_regs_if.slave            s_axi,
    output logic [NUM_REGS*AXI_DATA_W-1:0] o_regs,
    output logic                           o_wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]    o_wr_idx
);

    localparam int              IDX_W = $clog2(NUM_REGS);
    localparam logic [AXI_ADDR_W-1:0] SPAN = AXI_ADDR_W'(NUM_REGS * 4);

    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;

    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic                  addr_ok;
    logic [AXI_ADDR_W-1:0] offset;
    logic [IDX_W-1:0]      dec_idx;

    assign s_axi.awready = !aw_full_q;
    assign s_axi.wready  = !w_full_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign o_wr_pulse    = wr_pulse_q;
    assign o_wr_idx      = wr_idx_q;

    assign aw_hs = s_axi.awvalid && !aw_full_q;
    assign w_hs  = s_axi.wvalid && !w_full_q;

    // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of range.
    assign offset  = addr_q - BASE_ADDR;
    assign addr_ok = (addr_q[1:0] == 2'b00) && (offset < SPAN);
    assign dec_idx = offset[IDX_W+1:2];

    // A held pair may commit only once the B slot is free or being drained this edge.
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axi.bready);

    always_comb begin
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;

        if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_full_d  = 1'b0;
            w_full_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = addr_ok ? RESP_OKAY : RESP_SLVERR;
            wr_pulse_d = addr_ok;
            if (addr_ok) begin
                wr_idx_d = dec_idx;
            end
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    // Payload slots carry no reset; the full flags alone say whether they hold anything.
    always_ff @(posedge i_clk) begin
        if (aw_hs) begin
            addr_q <= s_axi.awaddr;
        end
        if (w_hs) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
        end
    end

    axil_regfile_bytewr #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .we_i     (commit && addr_ok),
        .idx_i    (dec_idx),
        .data_i   (wdata_q),
        .strb_i   (wstrb_q),
        .regs_o   (o_regs)
    );

endmodule

// File: tb/tb_axil_slave_wr_regs.sv
// Bench for axil_slave_wr_regs: directed scenarios plus randomized writes against a register model.
module tb_axil_slave_wr_regs;
    import axi_lite_pkg::*;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h0000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axil_slave_wr_regs_if s_axi();
    logic [NUM_REGS*32-1:0] regs_flat;
    logic                   wr_pulse;
    logic [3:0]             wr_idx;

    axil_slave_wr_regs #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .s_axi      (s_axi),
        .o_regs     (regs_flat),
        .o_wr_pulse (wr_pulse),
        .o_wr_idx   (wr_idx)
    );

    int total = 0;
    int passed = 0;
    int pulse_cnt = 0;
    logic [31:0] model [NUM_REGS];

    always @(posedge clk) begin
        if (wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] reg_of(input int k);
        return regs_flat[32*k +: 32];
    endfunction

    function automatic bit addr_valid(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 == 0) && (off < NUM_REGS * 4);
    endfunction

    function automatic int addr_index(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        if (!addr_valid(a)) return;
        k = addr_index(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axi.awvalid = 1'b0;
        s_axi.awaddr  = 32'h0;
        s_axi.wvalid  = 1'b0;
        s_axi.wdata   = 32'h0;
        s_axi.wstrb   = 4'h0;
    endtask

    // Drives one AW/W pair with independent start delays, then collects the B response.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output bit pulse, output logic [3:0] idx,
                            output bit tmo);
        bit aw_done, w_done, aw_hs, w_hs, seen;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; seen = 0;
        resp = 2'bxx; pulse = 0; idx = 4'h0; tmo = 0;
        s_axi.bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi.awvalid = !aw_done && (cyc >= aw_dly);
            s_axi.awaddr  = s_axi.awvalid ? a : 32'h0;
            s_axi.wvalid  = !w_done && (cyc >= w_dly);
            s_axi.wdata   = s_axi.wvalid ? d : 32'h0;
            s_axi.wstrb   = s_axi.wvalid ? s : 4'h0;
            aw_hs = s_axi.awvalid && s_axi.awready;
            w_hs  = s_axi.wvalid && s_axi.wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            if (s_axi.bvalid === 1'b1) begin
                resp = s_axi.bresp; pulse = wr_pulse; idx = wr_idx; seen = 1;
                break;
            end
            tick();
        end
        if (!(aw_done && w_done) || !seen) tmo = 1;
        else tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        s_axi.bready = 1'b0;
        resetn = 1'b0;
        repeat (2) tick();
        total++; if (s_axi.awready !== 1'b1) $display("FAIL rst_awready got=%0b exp=1", s_axi.awready); else passed++;
        total++; if (s_axi.wready !== 1'b1) $display("FAIL rst_wready got=%0b exp=1", s_axi.wready); else passed++;
        total++; if (s_axi.bvalid !== 1'b0) $display("FAIL rst_bvalid got=%0b exp=0", s_axi.bvalid); else passed++;
        total++; if (s_axi.bresp !== 2'b00) $display("FAIL rst_bresp got=%0b exp=00", s_axi.bresp); else passed++;
        total++; if ({wr_pulse, wr_idx} !== 5'h0) $display("FAIL rst_pulse_idx got=%0h exp=0", {wr_pulse, wr_idx}); else passed++;
        total++; if (regs_flat !== '0) $display("FAIL rst_regs got=%0h exp=0", regs_flat); else passed++;
        resetn = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_same_cycle();
        s_axi.bready = 1'b1;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h0000_0008;
        s_axi.wvalid = 1'b1;  s_axi.wdata = 32'hDEAD_BEEF; s_axi.wstrb = 4'hF;
        total++; if ({s_axi.awready, s_axi.wready} !== 2'b11) $display("FAIL same_ready got=%0b exp=11", {s_axi.awready, s_axi.wready}); else passed++;
        tick();
        idle_inputs();
        total++; if (s_axi.bvalid !== 1'b0) $display("FAIL same_early_bvalid got=%0b exp=0", s_axi.bvalid); else passed++;
        tick();
        model_write(32'h8, 32'hDEAD_BEEF, 4'hF);
        total++; if (s_axi.bvalid !== 1'b1) $display("FAIL same_bvalid got=%0b exp=1", s_axi.bvalid); else passed++;
        total++; if (s_axi.bresp !== 2'b00) $display("FAIL same_bresp got=%0b exp=00", s_axi.bresp); else passed++;
        total++; if (reg_of(2) !== 32'hDEAD_BEEF) $display("FAIL same_reg2 got=%0h exp=deadbeef", reg_of(2)); else passed++;
        total++; if (wr_pulse !== 1'b1) $display("FAIL same_pulse got=%0b exp=1", wr_pulse); else passed++;
        total++; if (wr_idx !== 4'd2) $display("FAIL same_idx got=%0d exp=2", wr_idx); else passed++;
        tick();
        total++; if ({s_axi.bvalid, wr_pulse} !== 2'b00) $display("FAIL same_after got=%0b exp=00", {s_axi.bvalid, wr_pulse}); else passed++;
    endtask

    task automatic test_w_leads();
        s_axi.bready = 1'b1;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h1234_5678; s_axi.wstrb = 4'hF;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++; if (s_axi.wready !== 1'b0) $display("FAIL wlead_wready c%0d got=%0b exp=0", i, s_axi.wready); else passed++;
            total++; if (s_axi.bvalid !== 1'b0) $display("FAIL wlead_bvalid c%0d got=%0b exp=0", i, s_axi.bvalid); else passed++;
            total++; if (reg_of(1) !== model[1]) $display("FAIL wlead_reg1_early c%0d got=%0h exp=%0h", i, reg_of(1), model[1]); else passed++;
            if (i < 2) tick();
        end
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h0000_0004;
        tick();
        idle_inputs();
        total++; if (s_axi.bvalid !== 1'b0) $display("FAIL wlead_latency got=%0b exp=0", s_axi.bvalid); else passed++;
        tick();
        model_write(32'h4, 32'h1234_5678, 4'hF);
        total++; if ({s_axi.bvalid, s_axi.bresp} !== 3'b100) $display("FAIL wlead_b got=%0b exp=100", {s_axi.bvalid, s_axi.bresp}); else passed++;
        total++; if (reg_of(1) !== 32'h1234_5678) $display("FAIL wlead_reg1 got=%0h exp=12345678", reg_of(1)); else passed++;
        total++; if ({wr_pulse, wr_idx} !== 5'h11) $display("FAIL wlead_pulse got=%0h exp=11", {wr_pulse, wr_idx}); else passed++;
        tick();
    endtask

    task automatic test_strobe();
        logic [1:0] resp; bit pulse; logic [3:0] idx; bit tmo;
        do_write(32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, pulse, idx, tmo);
        model_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        do_write(32'hC, 32'h0000_0000, 4'b0101, 1, 0, resp, pulse, idx, tmo);
        model_write(32'hC, 32'h0, 4'b0101);
        total++; if (tmo) $display("FAIL strb_timeout got=timeout exp=response"); else passed++;
        total++; if (resp !== 2'b00) $display("FAIL strb_resp got=%0b exp=00", resp); else passed++;
        total++; if (reg_of(3) !== 32'hFF00_FF00) $display("FAIL strb_reg3 got=%0h exp=ff00ff00", reg_of(3)); else passed++;
        do_write(32'hC, 32'h1234_5678, 4'h0, 0, 2, resp, pulse, idx, tmo);
        total++; if ({resp, pulse, idx} !== {2'b00, 1'b1, 4'd3}) $display("FAIL strb_zero got=%0b/%0b/%0d exp=00/1/3", resp, pulse, idx); else passed++;
        total++; if (reg_of(3) !== 32'hFF00_FF00) $display("FAIL strb_zero_reg3 got=%0h exp=ff00ff00", reg_of(3)); else passed++;
    endtask

    task automatic test_errors();
        logic [1:0] resp; bit pulse; logic [3:0] idx; bit tmo;
        int p0;
        p0 = pulse_cnt;
        do_write(32'h0000_0042, 32'hABCD_0123, 4'hF, 0, 0, resp, pulse, idx, tmo);
        total++; if ({tmo, resp, pulse} !== {1'b0, 2'b10, 1'b0}) $display("FAIL err_misalign got=%0b/%0b/%0b exp=0/10/0", tmo, resp, pulse); else passed++;
        do_write(32'h0000_0040, 32'hABCD_0123, 4'hF, 2, 0, resp, pulse, idx, tmo);
        total++; if ({tmo, resp, pulse} !== {1'b0, 2'b10, 1'b0}) $display("FAIL err_range got=%0b/%0b/%0b exp=0/10/0", tmo, resp, pulse); else passed++;
        total++; if (pulse_cnt !== p0) $display("FAIL err_pulse_cnt got=%0d exp=%0d", pulse_cnt, p0); else passed++;
        for (int k = 0; k < NUM_REGS; k++) begin
            total++; if (reg_of(k) !== model[k]) $display("FAIL err_reg%0d got=%0h exp=%0h", k, reg_of(k), model[k]); else passed++;
        end
        do_write(32'h0000_003C, 32'h0BAD_F00D, 4'hF, 0, 1, resp, pulse, idx, tmo);
        model_write(32'h3C, 32'h0BAD_F00D, 4'hF);
        total++; if ({resp, pulse, idx} !== {2'b00, 1'b1, 4'd15}) $display("FAIL err_top_reg got=%0b/%0b/%0d exp=00/1/15", resp, pulse, idx); else passed++;
        total++; if (reg_of(15) !== 32'h0BAD_F00D) $display("FAIL err_reg15 got=%0h exp=0badf00d", reg_of(15)); else passed++;
    endtask

    task automatic test_back_to_back();
        s_axi.bready = 1'b0;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h0000_0044;
        s_axi.wvalid = 1'b1;  s_axi.wdata = 32'hAAAA_5555; s_axi.wstrb = 4'hF;
        tick();
        idle_inputs();
        tick();
        total++; if ({s_axi.bvalid, s_axi.bresp} !== 3'b110) $display("FAIL b2b_first got=%0b exp=110", {s_axi.bvalid, s_axi.bresp}); else passed++;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h0000_0010;
        s_axi.wvalid = 1'b1;  s_axi.wdata = 32'hCAFE_F00D; s_axi.wstrb = 4'hF;
        total++; if ({s_axi.awready, s_axi.wready} !== 2'b11) $display("FAIL b2b_accept got=%0b exp=11", {s_axi.awready, s_axi.wready}); else passed++;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            total++; if ({s_axi.awready, s_axi.wready} !== 2'b00) $display("FAIL b2b_held_ready c%0d got=%0b exp=00", i, {s_axi.awready, s_axi.wready}); else passed++;
            total++; if ({s_axi.bvalid, s_axi.bresp} !== 3'b110) $display("FAIL b2b_held_b c%0d got=%0b exp=110", i, {s_axi.bvalid, s_axi.bresp}); else passed++;
            total++; if (reg_of(4) !== model[4]) $display("FAIL b2b_reg4_early c%0d got=%0h exp=%0h", i, reg_of(4), model[4]); else passed++;
            tick();
        end
        s_axi.bready = 1'b1;
        tick();
        model_write(32'h10, 32'hCAFE_F00D, 4'hF);
        total++; if ({s_axi.bvalid, s_axi.bresp} !== 3'b100) $display("FAIL b2b_second got=%0b exp=100", {s_axi.bvalid, s_axi.bresp}); else passed++;
        total++; if ({wr_pulse, wr_idx} !== 5'h14) $display("FAIL b2b_pulse got=%0h exp=14", {wr_pulse, wr_idx}); else passed++;
        total++; if (reg_of(4) !== 32'hCAFE_F00D) $display("FAIL b2b_reg4 got=%0h exp=cafef00d", reg_of(4)); else passed++;
        tick();
        total++; if (s_axi.bvalid !== 1'b0) $display("FAIL b2b_drain got=%0b exp=0", s_axi.bvalid); else passed++;
    endtask

    task automatic test_reset_mid();
        int p0;
        s_axi.bready = 1'b1;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h0000_0014;
        tick();
        idle_inputs();
        total++; if (s_axi.awready !== 1'b0) $display("FAIL rmid_awfull got=%0b exp=0", s_axi.awready); else passed++;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_clear();
        total++; if ({s_axi.awready, s_axi.wready, s_axi.bvalid} !== 3'b110) $display("FAIL rmid_flags got=%0b exp=110", {s_axi.awready, s_axi.wready, s_axi.bvalid}); else passed++;
        total++; if (regs_flat !== '0) $display("FAIL rmid_regs got=%0h exp=0", regs_flat); else passed++;
        p0 = pulse_cnt;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h0000_0055; s_axi.wstrb = 4'hF;
        tick();
        idle_inputs();
        repeat (4) tick();
        total++; if ({s_axi.wready, s_axi.bvalid} !== 2'b00) $display("FAIL rmid_w_alone got=%0b exp=00", {s_axi.wready, s_axi.bvalid}); else passed++;
        total++; if (pulse_cnt !== p0) $display("FAIL rmid_pulse got=%0d exp=%0d", pulse_cnt, p0); else passed++;
        total++; if (regs_flat !== '0) $display("FAIL rmid_regs2 got=%0h exp=0", regs_flat); else passed++;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] resp; bit pulse; logic [3:0] idx; bit tmo;
        logic [31:0] a, d; logic [3:0] s;
        logic [1:0] exp_resp;
        int sel, k;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 5);
            k = $urandom_range(0, NUM_REGS - 1);
            if (sel <= 3)      a = BASE + 32'(k * 4);
            else if (sel == 4) a = BASE + 32'(k * 4) + 32'($urandom_range(1, 3));
            else               a = BASE + 32'(NUM_REGS * 4) + 32'($urandom_range(0, 255) * 4);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            exp_resp = addr_valid(a) ? 2'b00 : 2'b10;
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, idx, tmo);
            model_write(a, d, s);
            total++; if (tmo) $display("FAIL rnd_timeout it%0d got=timeout exp=response", it); else passed++;
            total++; if (resp !== exp_resp) $display("FAIL rnd_resp it%0d addr=%0h got=%0b exp=%0b", it, a, resp, exp_resp); else passed++;
            total++; if (pulse !== addr_valid(a)) $display("FAIL rnd_pulse it%0d got=%0b exp=%0b", it, pulse, addr_valid(a)); else passed++;
            if (addr_valid(a)) begin
                total++; if (idx !== 4'(addr_index(a))) $display("FAIL rnd_idx it%0d got=%0d exp=%0d", it, idx, addr_index(a)); else passed++;
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            total++; if (reg_of(r) !== model[r]) $display("FAIL rnd_reg%0d got=%0h exp=%0h", r, reg_of(r), model[r]); else passed++;
        end
    endtask

    initial begin
        idle_inputs();
        s_axi.bready = 1'b0;
        model_clear();
        test_reset();
        test_same_cycle();
        test_w_leads();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
